// File: rtl/gpu_reg_bank_responder.sv
// Warp register-bank responder: arbitrates per-warp reads and writes onto a single-ported
// register file, with a one-entry read response buffer. Optional parity: REG_BANK_PARITY_EN.
module gpu_reg_bank_responder #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_REGS      = 64,
    parameter int DATA_W        = 256,
    parameter int WR_STARVE_MAX = 8,
    localparam int WARP_AW      = $clog2(NUM_WARPS),
    localparam int REG_AW       = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WARPS-1:0]          rd_req_valid,
    input  logic [NUM_WARPS*REG_AW-1:0]   rd_req_reg,
    output logic [NUM_WARPS-1:0]          rd_req_ready,
    input  logic [NUM_WARPS-1:0]          wr_req_valid,
    input  logic [NUM_WARPS*REG_AW-1:0]   wr_req_reg,
    input  logic [NUM_WARPS*DATA_W-1:0]   wr_req_data,
    output logic [NUM_WARPS-1:0]          wr_req_ready,
    output logic                          rd_resp_valid,
    output logic [WARP_AW-1:0]            rd_resp_warp,
    output logic [REG_AW-1:0]             rd_resp_reg,
    output logic [DATA_W-1:0]             rd_resp_data,
    input  logic                          rd_resp_ready,
`ifdef REG_BANK_PARITY_EN
    input  logic                          perr_inject,
    output logic                          rd_resp_perr,
`endif
    output logic                          busy
);

    localparam int SC_W  = $clog2(WR_STARVE_MAX + 1);
    localparam int DEPTH = NUM_WARPS * NUM_REGS;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic                     resp_valid_q;
    logic [WARP_AW-1:0]       resp_warp_q;
    logic [REG_AW-1:0]        resp_reg_q;
    logic [DATA_W-1:0]        resp_data_q;
    logic [WARP_AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [WARP_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [SC_W-1:0]          starve_q, starve_d;

    logic                     resp_free, force_wr;
    logic                     rd_found, wr_found, rd_gnt, wr_gnt;
    logic [WARP_AW-1:0]       rd_sel, wr_sel, idx;
    logic [REG_AW-1:0]        rd_reg, wr_reg;
    logic [DATA_W-1:0]        wr_data;
    logic [WARP_AW+REG_AW-1:0] rd_addr, wr_addr;

    always_comb begin
        resp_free = !resp_valid_q || rd_resp_ready;
        force_wr  = (starve_q == SC_W'(WR_STARVE_MAX)) && (|wr_req_valid);
        rd_found  = 1'b0;
        wr_found  = 1'b0;
        rd_sel    = '0;
        wr_sel    = '0;
        idx       = '0;
        // Round-robin: first requester at or after the pointer wins.
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = rd_ptr_q + WARP_AW'(i);
            if (!rd_found && rd_req_valid[idx]) begin
                rd_found = 1'b1;
                rd_sel   = idx;
            end
            idx = wr_ptr_q + WARP_AW'(i);
            if (!wr_found && wr_req_valid[idx]) begin
                wr_found = 1'b1;
                wr_sel   = idx;
            end
        end
        rd_gnt       = rst && !force_wr && resp_free && rd_found;
        wr_gnt       = rst && !rd_gnt && wr_found;
        rd_req_ready = rd_gnt ? (NUM_WARPS'(1) << rd_sel) : '0;
        wr_req_ready = wr_gnt ? (NUM_WARPS'(1) << wr_sel) : '0;
        rd_reg       = rd_req_reg[rd_sel*REG_AW +: REG_AW];
        wr_reg       = wr_req_reg[wr_sel*REG_AW +: REG_AW];
        wr_data      = wr_req_data[wr_sel*DATA_W +: DATA_W];
        rd_addr      = {rd_sel, rd_reg};
        wr_addr      = {wr_sel, wr_reg};

        rd_ptr_d = rd_gnt ? rd_sel + WARP_AW'(1) : rd_ptr_q;
        wr_ptr_d = wr_gnt ? wr_sel + WARP_AW'(1) : wr_ptr_q;
        if ((|wr_req_valid) && !wr_gnt)
            starve_d = (starve_q == SC_W'(WR_STARVE_MAX)) ? starve_q : starve_q + SC_W'(1);
        else
            starve_d = '0;
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_gnt)
            mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_warp_q  <= '0;
            resp_reg_q   <= '0;
            resp_data_q  <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            starve_q     <= '0;
        end else begin
            if (rd_gnt) begin
                resp_valid_q <= 1'b1;
                resp_warp_q  <= rd_sel;
                resp_reg_q   <= rd_reg;
                resp_data_q  <= mem_q[rd_addr];
            end else if (rd_resp_ready) begin
                resp_valid_q <= 1'b0;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            starve_q <= starve_d;
        end
    end

`ifdef REG_BANK_PARITY_EN
    logic par_q [DEPTH];
    logic perr_q;

    always_ff @(posedge clk) begin
        if (wr_gnt)
            par_q[wr_addr] <= (^wr_data) ^ perr_inject;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perr_q <= 1'b0;
        else if (rd_gnt)
            perr_q <= par_q[rd_addr] ^ (^mem_q[rd_addr]);
    end

    assign rd_resp_perr = perr_q;
`endif

    assign rd_resp_valid = resp_valid_q;
    assign rd_resp_warp  = resp_warp_q;
    assign rd_resp_reg   = resp_reg_q;
    assign rd_resp_data  = resp_data_q;
    assign busy          = (|rd_req_valid) || (|wr_req_valid) || resp_valid_q;

endmodule
